// File: rtl/omsp_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and a two's-complement magnitude helper.
package omsp_div_pkg;

    localparam int unsigned DIV_WIDTH   = 16;
    localparam int unsigned DIV_WMAX    = 64;
    localparam int unsigned DIV_WMAX_LG = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Magnitude of a w-bit two's-complement value held in the low bits of x;
    // callers truncate the result back to w bits.
    function automatic logic [DIV_WMAX-1:0] abs_w(input logic [DIV_WMAX-1:0] x,
                                                  input int unsigned         w);
        logic [DIV_WMAX-1:0] res;
        res = x[DIV_WMAX_LG'(w - 1)] ? (~x + DIV_WMAX'(1)) : x;
        return res;
    endfunction

endpackage

// File: rtl/omsp_div_addsub.sv
// Combinational a + ~b + 1 subtractor shared by the divide step and the
// final sign fix-up negations.
module omsp_div_addsub #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    localparam int unsigned SW = W + 1;

    logic [W:0] w_sum;

    assign w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + SW'(1);
    assign o_diff   = w_sum[W-1:0];
    assign o_borrow = ~w_sum[W];

endmodule

// File: rtl/omsp_alu_seq_divider.sv
// Iterative restoring divider, one quotient bit per mclk, signed or unsigned,
// with start/done handshake and divide-by-zero / MIN-by-minus-one flags.
module omsp_alu_seq_divider
    import omsp_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             div_ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SUB_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e r_state;
    div_state_e w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_zero;
    logic             r_ovf_pend;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_by_zero;
    logic             r_ovf;

    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [SUB_W-1:0] w_step_a;
    logic [SUB_W-1:0] w_step_b;
    logic [SUB_W-1:0] w_step_diff;
    logic             w_step_borrow;
    logic [SUB_W-1:0] w_nrem_diff;
    logic             w_nrem_borrow;
    logic             w_unused_bits;

    assign w_div0    = (divisor == '0);
    assign w_ovf     = div_signed && (dividend == MIN_VAL) && (divisor == '1);
    assign w_dvd_mag = div_signed ? WIDTH'(abs_w(DIV_WMAX'(dividend), WIDTH)) : dividend;
    assign w_dvs_mag = div_signed ? WIDTH'(abs_w(DIV_WMAX'(divisor), WIDTH)) : divisor;

    // One subtractor: trial subtract while running, quotient negation in FIX.
    assign w_step_a = (r_state == ST_FIX) ? '0 : {r_rem, r_q[WIDTH-1]};
    assign w_step_b = (r_state == ST_FIX) ? {1'b0, r_q} : {1'b0, r_dvs};

    omsp_div_addsub #(.W(SUB_W)) u_step (
        .i_a      (w_step_a),
        .i_b      (w_step_b),
        .o_diff   (w_step_diff),
        .o_borrow (w_step_borrow)
    );

    omsp_div_addsub #(.W(SUB_W)) u_neg_rem (
        .i_a      ('0),
        .i_b      ({1'b0, r_rem}),
        .o_diff   (w_nrem_diff),
        .o_borrow (w_nrem_borrow)
    );

    assign w_unused_bits = &{1'b0, w_step_diff[WIDTH], w_nrem_diff[WIDTH], w_nrem_borrow};

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (div_start) w_state_nxt = w_div0 ? ST_FIX : ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, shift/subtract iterations and result fix-up.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_remd     <= '0;
            r_by_zero  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (div_start) begin
                        r_cnt      <= CNT_W'(WIDTH - 1);
                        r_rem      <= '0;
                        // Divide-by-zero parks the raw dividend for the remainder.
                        r_q        <= w_div0 ? dividend : w_dvd_mag;
                        r_dvs      <= w_dvs_mag;
                        r_neg_q    <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= div_signed && dividend[WIDTH-1];
                        r_zero     <= w_div0;
                        r_ovf_pend <= w_ovf;
                        r_busy     <= 1'b1;
                        r_by_zero  <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_step_borrow ? w_step_a[WIDTH-1:0] : w_step_diff[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], ~w_step_borrow};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    if (r_zero) begin
                        r_quot <= '1;
                        r_remd <= r_q;
                    end else begin
                        r_quot <= r_neg_q ? w_step_diff[WIDTH-1:0] : r_q;
                        r_remd <= r_neg_r ? w_nrem_diff[WIDTH-1:0] : r_rem;
                    end
                    r_by_zero <= r_zero;
                    r_ovf     <= r_ovf_pend;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign div_busy    = r_busy;
    assign div_done    = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_by_zero;
    assign div_ovf     = r_ovf;

endmodule
